// File: rtl/ir_issue_ctrl.sv
// Issue sequencer between the RV32 decoder and execute: per-register write
// scoreboard, RAW/WAW-overflow stalls, branch serialisation, one issue slot.
module ir_issue_ctrl #(
  parameter int PW    = 64,
  parameter int CNT_W = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dec_valid,
  output logic          dec_ready,
  input  logic [4:0]    dec_rs1,
  input  logic [4:0]    dec_rs2,
  input  logic [4:0]    dec_rd,
  input  logic          dec_use_rs1,
  input  logic          dec_use_rs2,
  input  logic          dec_w,
  input  logic          dec_bj,
  input  logic [PW-1:0] dec_payload,
  output logic          iss_valid,
  input  logic          iss_ready,
  output logic [PW-1:0] iss_payload,
  input  logic          wb_valid,
  input  logic [4:0]    wb_rd,
  input  logic          br_done,
  output logic [31:0]   sb_busy,
  output logic          sb_err
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           r_state;
  logic             r_iss_valid;
  logic [PW-1:0]    r_iss_payload;
  logic             r_sb_err;
  logic [CNT_W-1:0] r_cnt [32];

  logic        w_raw1;
  logic        w_raw2;
  logic        w_waw;
  logic        w_slot_free;
  logic        w_ready;
  logic        w_accept;
  logic        w_consume;
  logic        w_inc_en;
  logic        w_dec_en;
  logic        w_wb_err;
  logic [31:0] w_inc_vec;
  logic [31:0] w_dec_vec;
  logic [31:0] w_busy;

  // Hazard detection looks only at registered counters: a same-cycle
  // writeback does not release a dependent instruction.
  always_comb begin
    w_raw1      = dec_use_rs1 & (dec_rs1 != 5'd0) & (r_cnt[dec_rs1] != CNT_ZERO);
    w_raw2      = dec_use_rs2 & (dec_rs2 != 5'd0) & (r_cnt[dec_rs2] != CNT_ZERO);
    w_waw       = dec_w & (dec_rd != 5'd0) & (r_cnt[dec_rd] == CNT_MAX);
    w_slot_free = ~r_iss_valid | iss_ready;
    w_ready     = rst_n & (r_state == ST_RUN) & w_slot_free & ~w_raw1 & ~w_raw2 & ~w_waw;
    w_accept    = dec_valid & w_ready;
    w_consume   = r_iss_valid & iss_ready;
    w_inc_en    = w_accept & dec_w & (dec_rd != 5'd0);
    w_dec_en    = wb_valid & (wb_rd != 5'd0);
    w_wb_err    = w_dec_en & (r_cnt[wb_rd] == CNT_ZERO) & ~(w_inc_en & (dec_rd == wb_rd));
  end

  // One-hot increment/decrement requests per architectural register.
  always_comb begin
    w_inc_vec = 32'd0;
    w_dec_vec = 32'd0;
    if (w_inc_en) begin
      w_inc_vec = 32'd1 << dec_rd;
    end else begin
      w_inc_vec = 32'd0;
    end
    if (w_dec_en) begin
      w_dec_vec = 32'd1 << wb_rd;
    end else begin
      w_dec_vec = 32'd0;
    end
  end

  // Pending-write counters; a simultaneous inc and dec on one register cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_cnt[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (w_inc_vec[i] && !w_dec_vec[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end else if (w_dec_vec[i] && !w_inc_vec[i] && (r_cnt[i] != CNT_ZERO)) begin
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
        end else begin
          r_cnt[i] <= r_cnt[i];
        end
      end
    end
  end

  // Control-flow FSM together with the issue slot and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_iss_valid   <= 1'b0;
      r_iss_payload <= '0;
      r_sb_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_accept && dec_bj) begin
            r_state <= ST_BR_WAIT;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_BR_WAIT: begin
          if (br_done) begin
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_BR_WAIT;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase

      if (w_accept) begin
        r_iss_valid   <= 1'b1;
        r_iss_payload <= dec_payload;
      end else if (w_consume) begin
        r_iss_valid   <= 1'b0;
        r_iss_payload <= r_iss_payload;
      end else begin
        r_iss_valid   <= r_iss_valid;
        r_iss_payload <= r_iss_payload;
      end

      if (w_wb_err) begin
        r_sb_err <= 1'b1;
      end else begin
        r_sb_err <= r_sb_err;
      end
    end
  end

  // Busy view of the scoreboard; x0 is never tracked.
  always_comb begin
    w_busy = 32'd0;
    for (int i = 1; i < 32; i++) begin
      w_busy[i] = (r_cnt[i] != CNT_ZERO);
    end
  end

  assign dec_ready   = w_ready;
  assign iss_valid   = r_iss_valid;
  assign iss_payload = r_iss_payload;
  assign sb_busy     = w_busy;
  assign sb_err      = r_sb_err;

endmodule

// File: tb/tb_ir_issue_ctrl.sv
// Scoreboard bench for ir_issue_ctrl: a reference model predicts handshake and
// scoreboard outputs, a payload queue checks issue order and slot stability.
module tb_ir_issue_ctrl;
  localparam int PW   = 64;
  localparam int MAXC = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dec_valid;
  logic          dec_ready;
  logic [4:0]    dec_rs1, dec_rs2, dec_rd;
  logic          dec_use_rs1, dec_use_rs2, dec_w, dec_bj;
  logic [PW-1:0] dec_payload;
  logic          iss_valid;
  logic          iss_ready;
  logic [PW-1:0] iss_payload;
  logic          wb_valid;
  logic [4:0]    wb_rd;
  logic          br_done;
  logic [31:0]   sb_busy;
  logic          sb_err;

  int n_tests = 0;
  int n_fail  = 0;

  int            m_cnt [32];
  bit            m_state;
  bit            m_iv;
  bit            m_err;
  logic [PW-1:0] q [$];

  ir_issue_ctrl #(.PW(PW), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_w(dec_w), .dec_bj(dec_bj), .dec_payload(dec_payload),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .br_done(br_done),
    .sb_busy(sb_busy), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_state = 1'b0;
    m_iv    = 1'b0;
    m_err   = 1'b0;
    q.delete();
  endtask

  function automatic bit model_ready();
    return rst_n && !m_state && (!m_iv || iss_ready)
      && !(dec_use_rs1 && dec_rs1 != 5'd0 && m_cnt[dec_rs1] != 0)
      && !(dec_use_rs2 && dec_rs2 != 5'd0 && m_cnt[dec_rs2] != 0)
      && !(dec_w && dec_rd != 5'd0 && m_cnt[dec_rd] == MAXC);
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = 32'd0;
    for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit w, input bit bj);
    dec_valid   = v;
    dec_rs1     = 5'(rs1);
    dec_rs2     = 5'(rs2);
    dec_rd      = 5'(rd);
    dec_use_rs1 = u1;
    dec_use_rs2 = u2;
    dec_w       = w;
    dec_bj      = bj;
    dec_payload = {$urandom(), $urandom()};
  endtask

  // One clock: compare at negedge, advance the model, return just after posedge.
  task automatic step();
    bit exp_rdy, acc, inc, dcr;
    @(negedge clk);
    exp_rdy = model_ready();
    check("dec_ready", {63'd0, dec_ready}, {63'd0, exp_rdy});
    check("iss_valid", {63'd0, iss_valid}, {63'd0, m_iv});
    check("sb_busy", {32'd0, sb_busy}, {32'd0, model_busy()});
    check("sb_err", {63'd0, sb_err}, {63'd0, m_err});
    if (m_iv) begin
      if (q.size() == 0) check("sb_queue_empty", 64'd1, 64'd0);
      else if (iss_ready) check("iss_payload", iss_payload, q.pop_front());
      else check("iss_payload_hold", iss_payload, q[0]);
    end
    acc = dec_valid && exp_rdy;
    if (acc) q.push_back(dec_payload);
    inc = acc && dec_w && dec_rd != 5'd0;
    dcr = wb_valid && wb_rd != 5'd0;
    if (!(inc && dcr && dec_rd == wb_rd)) begin
      if (dcr) begin
        if (m_cnt[wb_rd] == 0) m_err = 1'b1;
        else m_cnt[wb_rd]--;
      end
      if (inc) m_cnt[dec_rd]++;
    end
    if (!m_state && acc && dec_bj) m_state = 1'b1;
    else if (m_state && br_done) m_state = 1'b0;
    if (acc) m_iv = 1'b1;
    else if (m_iv && iss_ready) m_iv = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [PW-1:0] saved;

  initial begin
    rst_n = 1'b0;
    iss_ready = 1'b1;
    wb_valid = 1'b0;
    wb_rd = 5'd0;
    br_done = 1'b0;
    drive(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    check("rst_dec_ready", {63'd0, dec_ready}, 64'd0);
    check("rst_iss_valid", {63'd0, iss_valid}, 64'd0);
    check("rst_iss_payload", iss_payload, 64'd0);
    check("rst_sb_busy", {32'd0, sb_busy}, 64'd0);
    check("rst_sb_err", {63'd0, sb_err}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    dec_valid = 1'b0;

    // Independent ADD stream, rd=1..4
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8 + 2 * i, 1'b1, 9 + 2 * i, 1'b1, i, 1'b1, 1'b0);
      step();
    end
    check("stream_busy", {32'd0, sb_busy}, 64'h1E);
    dec_valid = 1'b0;
    step();
    for (int i = 1; i <= 4; i++) begin
      wb_valid = 1'b1;
      wb_rd = 5'(i);
      step();
    end
    wb_valid = 1'b0;
    check("stream_drained", {32'd0, sb_busy}, 64'd0);

    // RAW stall on LW x5
    drive(1'b1, 1, 1'b1, 0, 1'b0, 5, 1'b1, 1'b0);
    step();
    drive(1'b1, 5, 1'b1, 2, 1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("raw_stall", {63'd0, dec_ready}, 64'd0);
    end
    wb_valid = 1'b1;
    wb_rd = 5'd5;
    step();
    wb_valid = 1'b0;
    check("raw_release", {63'd0, dec_ready}, 64'd1);
    step();
    dec_valid = 1'b0;
    step();
    check("raw_busy5", {63'd0, sb_busy[5]}, 64'd0);

    // WAW saturation on x7
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b0);
      step();
    end
    drive(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b0);
    step();
    check("waw_stall", {63'd0, dec_ready}, 64'd0);
    step();
    wb_valid = 1'b1;
    wb_rd = 5'd7;
    step();
    wb_valid = 1'b0;
    check("waw_release", {63'd0, dec_ready}, 64'd1);
    step();
    drive(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b0);
    step();
    check("waw_full_again", {63'd0, dec_ready}, 64'd0);
    dec_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1;
      wb_rd = 5'd7;
      step();
    end
    wb_valid = 1'b0;
    check("waw_drained", {32'd0, sb_busy}, 64'd0);

    // Branch serialisation
    drive(1'b1, 1, 1'b1, 2, 1'b1, 0, 1'b0, 1'b1);
    step();
    drive(1'b1, 3, 1'b1, 4, 1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("br_wait_stall", {63'd0, dec_ready}, 64'd0);
    end
    br_done = 1'b1;
    step();
    br_done = 1'b0;
    check("br_resume", {63'd0, dec_ready}, 64'd1);
    step();
    dec_valid = 1'b0;
    step();

    // Backpressure: slot held while execute stalls
    iss_ready = 1'b0;
    drive(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    saved = dec_payload;
    step();
    drive(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_payload", iss_payload, saved);
      check("bp_ready", {63'd0, dec_ready}, 64'd0);
    end
    iss_ready = 1'b1;
    step();
    dec_valid = 1'b0;
    step();

    // Same-cycle increment and writeback on x9
    drive(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b0);
    step();
    drive(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b0);
    wb_valid = 1'b1;
    wb_rd = 5'd9;
    step();
    wb_valid = 1'b0;
    dec_valid = 1'b0;
    step();
    check("simul_busy9", {63'd0, sb_busy[9]}, 64'd1);
    check("simul_err", {63'd0, sb_err}, 64'd0);
    wb_valid = 1'b1;
    step();
    wb_valid = 1'b0;
    check("simul_cnt_was1", {63'd0, sb_busy[9]}, 64'd0);

    // Writeback to x0 ignored; writeback to idle x12 is an error
    wb_valid = 1'b1;
    wb_rd = 5'd0;
    step();
    check("wb_x0_no_err", {63'd0, sb_err}, 64'd0);
    wb_rd = 5'd12;
    step();
    wb_valid = 1'b0;
    check("err_set", {63'd0, sb_err}, 64'd1);
    step();
    step();
    check("err_sticky", {63'd0, sb_err}, 64'd1);

    // Async reset in BR_WAIT with counters pending
    drive(1'b1, 0, 1'b0, 0, 1'b0, 20, 1'b1, 1'b0);
    step();
    drive(1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1, 1'b1);
    step();
    drive(1'b1, 2, 1'b1, 3, 1'b1, 0, 1'b0, 1'b0);
    step();
    check("pre_rst_busy", {32'd0, sb_busy}, 64'h0010_0002);
    #2 rst_n = 1'b0;
    #1;
    check("arst_iss_valid", {63'd0, iss_valid}, 64'd0);
    check("arst_sb_busy", {32'd0, sb_busy}, 64'd0);
    check("arst_sb_err", {63'd0, sb_err}, 64'd0);
    check("arst_dec_ready", {63'd0, dec_ready}, 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("post_rst_run", {63'd0, iss_valid}, 64'd1);
    dec_valid = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ir_issue_ctrl.md
Name: ir_issue_ctrl

Overview:
Issue sequencer between the RV32 instruction decoder and the execute stage. It accepts decoded instructions over a valid/ready handshake and tracks in-flight register writes in a per-register scoreboard, stalling on RAW and WAW-overflow hazards. It also serialises control flow by blocking further issue after a branch or jump until execute reports resolution. It presents one registered issue slot to execute.

Parameters:
PW, 64, width of the opaque decoded payload passed through to execute
CNT_W, 2, width of each per-register pending-write counter; max in-flight writes per rd = 2^CNT_W-1

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
dec_valid  in  1  decoder holds a valid instruction
dec_ready  out  1  controller accepts the instruction this cycle
dec_rs1  in  5  source register 1
dec_rs2  in  5  source register 2
dec_rd  in  5  destination register
dec_use_rs1  in  1  instruction reads rs1
dec_use_rs2  in  1  instruction reads rs2
dec_w  in  1  instruction writes rd (cs.w)
dec_bj  in  1  instruction is a branch or jump (cs.b | cs.j)
dec_payload  in  PW  decoded fields (imm, alu_src_sel, cs, func3/7), passed through
iss_valid  out  1  issue slot holds an instruction
iss_ready  in  1  execute consumes the slot this cycle
iss_payload  out  PW  registered copy of dec_payload
wb_valid  in  1  a register write completes this cycle
wb_rd  in  5  register written
br_done  in  1  execute has resolved the outstanding branch/jump
sb_busy  out  32  bit r = counter[r] != 0; bit 0 always 0
sb_err  out  1  sticky: wb_valid seen for a register whose counter was 0

Behaviour:
- Reset (async, rst_n=0): state=RUN, all counters 0, iss_valid=0, iss_payload=0, sb_err=0, dec_ready=0 while in reset.
- States: RUN (normal issue), BR_WAIT (control flow outstanding).
- Hazard, evaluated on registered counters only; same-cycle writeback does not bypass:
  - raw1 = dec_use_rs1 & rs1!=0 & cnt[rs1]!=0
  - raw2 = likewise for rs2
  - waw = dec_w & rd!=0 & cnt[rd]==max
- dec_ready = (state==RUN) & (!iss_valid | iss_ready) & !raw1 & !raw2 & !waw.
- dec_ready does not depend on dec_valid.
- Accept = dec_valid & dec_ready. On accept:
  - iss_payload <= dec_payload; iss_valid <= 1.
  - If dec_w & rd!=0, cnt[rd] increments.
- Consume = iss_valid & iss_ready. On consume without accept, iss_valid <= 0. Consume and accept in the same cycle gives back-to-back issue, 1 instruction/cycle.
- Latency: accept in cycle N -> iss_valid in cycle N+1.
- iss_payload is held stable while iss_valid & !iss_ready.
- Writeback: if wb_valid & wb_rd!=0:
  - cnt[wb_rd]!=0: cnt[wb_rd] decrements.
  - cnt[wb_rd]==0: counter unchanged, sb_err <= 1 (sticky until reset).
- Same-register increment and decrement in one cycle: counter unchanged, no error if the pre-count is 0.
- wb to x0 is ignored.
- Transitions:
  - RUN -> BR_WAIT on accept with dec_bj=1. The branch itself is issued normally; JAL/JALR rd is tracked like any write.
  - BR_WAIT -> RUN on br_done. dec_ready may assert the cycle after br_done.
  - br_done in RUN is ignored.
  - In BR_WAIT, dec_ready=0 while the issue slot still drains and writebacks still retire.
- Counters never wrap; the waw stall guarantees this.
- No flush input. Fetch discards the wrong path itself, because nothing is accepted in BR_WAIT.

Test Plan:
- Independent stream: 4× ADD with rd=1..4 and disjoint sources, iss_ready=1 -> dec_ready stays 1, iss_valid high cycles 1–4, sb_busy=0x1E after cycle 4.
- RAW stall: LW x5 accepted, then ADD rs1=x5 -> dec_ready=0 until the cycle after wb_valid/wb_rd=5, then ADD is accepted; sb_busy[5] returns to 0.
- WAW saturation (CNT_W=2): 3 writes to x7 without writeback, then a 4th -> 4th stalls; one wb to x7 -> 4th accepted the next cycle, counter=3.
- Branch: BEQ accepted -> state BR_WAIT, dec_ready=0 for 5 cycles despite dec_valid=1; br_done pulse -> next instruction accepted one cycle later.
- Backpressure/simultaneity: iss_ready=0 for 3 cycles -> iss_payload stable, dec_ready=0. Same-cycle accept of write x9 and wb x9 with cnt=1 -> cnt stays 1, sb_err=0.
- Error and reset: wb_rd=12 with cnt 0 -> sb_err=1 sticky. rst_n low mid-BR_WAIT with counters nonzero -> immediately iss_valid=0, sb_busy=0, sb_err=0, state RUN.
